// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: column/row counters with registered sync, blanking and
// line/frame start pulses, all aligned to the counter values presented in the same cycle.
module vga_timing_gen #(
    parameter int HVID  = 640,
    parameter int HFP   = 16,
    parameter int HSYNC = 96,
    parameter int HBP   = 48,
    parameter int VVID  = 480,
    parameter int VFP   = 10,
    parameter int VSYNC = 2,
    parameter int VBP   = 33
) (
    input  logic       clk_25,
    input  logic       rst,
    input  logic       en,
    output logic [9:0] horizontal_num,
    output logic [9:0] vertical_num,
    output logic       hsync,
    output logic       vsync,
    output logic       load_enable,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = HVID + HFP + HSYNC + HBP;
    localparam int V_TOTAL = VVID + VFP + VSYNC + VBP;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    // Decode bounds are one bit wider so an end bound of exactly 1024 stays representable.
    localparam logic [10:0] HS_START = 11'(HVID + HFP);
    localparam logic [10:0] HS_END   = 11'(HVID + HFP + HSYNC);
    localparam logic [10:0] VS_START = 11'(VVID + VFP);
    localparam logic [10:0] VS_END   = 11'(VVID + VFP + VSYNC);
    localparam logic [10:0] H_ACT    = 11'(HVID);
    localparam logic [10:0] V_ACT    = 11'(VVID);

    logic [9:0] hCount_q, hCount_d;
    logic [9:0] vCount_q, vCount_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       blank_q, blank_d;
    logic       lineStart_q, lineStart_d;
    logic       frameStart_q, frameStart_d;
    logic       hWrap, vWrap;
    logic [10:0] hExt, vExt;

    // Decoded outputs come from the next counter values so they register alongside them.
    always_comb begin
        hWrap        = (hCount_q == H_LAST);
        vWrap        = (vCount_q == V_LAST);
        hCount_d     = hCount_q;
        vCount_d     = vCount_q;
        lineStart_d  = 1'b0;
        frameStart_d = 1'b0;
        if (en) begin
            if (hWrap) begin
                hCount_d     = '0;
                vCount_d     = vWrap ? '0 : vCount_q + 10'd1;
                lineStart_d  = 1'b1;
                frameStart_d = vWrap;
            end else begin
                hCount_d = hCount_q + 10'd1;
            end
        end
        hExt    = {1'b0, hCount_d};
        vExt    = {1'b0, vCount_d};
        hsync_d = !((hExt >= HS_START) && (hExt < HS_END));
        vsync_d = !((vExt >= VS_START) && (vExt < VS_END));
        blank_d = (hExt >= H_ACT) || (vExt >= V_ACT);
    end

    always_ff @(posedge clk_25 or posedge rst) begin
        if (rst) begin
            hCount_q     <= '0;
            vCount_q     <= '0;
            hsync_q      <= 1'b1;
            vsync_q      <= 1'b1;
            blank_q      <= 1'b0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            blank_q      <= blank_d;
            lineStart_q  <= lineStart_d;
            frameStart_q <= frameStart_d;
        end
    end

    assign horizontal_num = hCount_q;
    assign vertical_num   = vCount_q;
    assign hsync          = hsync_q;
    assign vsync          = vsync_q;
    assign load_enable    = blank_q;
    assign line_start     = lineStart_q;
    assign frame_start    = frameStart_q;

endmodule
